// File: rtl/hook_pkg.sv
// Shared types, per-angle step tables and the tail position helper for the hook controller.
package hook_pkg;

    typedef enum logic [1:0] {
        SWING   = 2'd0,
        EXTEND  = 2'd1,
        RETRACT = 2'd2,
        LOADED  = 2'd3
    } hook_state_t;

    // Extend-direction step per R_mode; index 5 points straight down.
    localparam logic signed [3:0] DX [0:10] = '{
        -4'sd6, -4'sd6, -4'sd5, -4'sd4, -4'sd2, 4'sd0,
         4'sd2,  4'sd4,  4'sd5,  4'sd6,  4'sd6
    };
    localparam logic signed [3:0] DY [0:10] = '{
         4'sd0,  4'sd1,  4'sd2,  4'sd3,  4'sd4, 4'sd6,
         4'sd4,  4'sd3,  4'sd2,  4'sd1,  4'sd0
    };

    function automatic logic signed [10:0] tail_pos(
        input logic [9:0]        origin,
        input logic [6:0]        n,
        input logic signed [3:0] d
    );
        logic signed [10:0] nn;
        logic signed [10:0] dd;
        nn = signed'({4'b0000, n});
        dd = {{7{d[3]}}, d};
        return signed'({1'b0, origin}) + nn * dd;
    endfunction

endpackage

// File: rtl/hook_if.sv
// Catch interface between the hook (master) and the gold/stone sprites (slave).
interface hook_if;
    logic [9:0] tailx;
    logic [9:0] taily;
    logic [3:0] R_mode;
    logic [2:0] state_out;
    logic       is_explode;
    logic       is_catch_any;

    modport master (
        output tailx, taily, R_mode, state_out, is_explode,
        input  is_catch_any
    );

    modport slave (
        input  tailx, taily, R_mode, state_out, is_explode,
        output is_catch_any
    );
endinterface

// File: rtl/hook_tick_gen.sv
// Step-rate divider: counts up to div, pulses tick for one cycle and restarts; clear restarts it early.
module hook_tick_gen (
    input  logic        Clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [31:0] div,
    output logic        tick
);
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    assign tick = (cnt_q >= div);

    always_comb begin
        cnt_d = cnt_q + 32'd1;
        if (clear || tick) cnt_d = '0;
    end

    always_ff @(posedge Clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/hook_controller.sv
// Claw/hook driver: swings, extends, retracts empty or loaded, and publishes the tail to the sprites.
// Optional HOOK_DYNAMITE_EN: dynamite_fire in LOADED drops the load and pulses is_explode.
//
// state   | meaning
// SWING   | hook pivots through R_mode 0..10, waits for a fire edge
// EXTEND  | tail moves outward one step per tick
// RETRACT | tail returns empty at the fast rate
// LOADED  | tail returns with a sprite attached at the slow rate
module hook_controller
    import hook_pkg::*;
#(
    parameter logic [9:0]  ORIGIN_X  = 10'd320,
    parameter logic [9:0]  ORIGIN_Y  = 10'd60,
    parameter logic [31:0] SWING_DIV = 32'd4000000,
    parameter logic [31:0] EXT_DIV   = 32'd1000000,
    parameter logic [31:0] LOAD_DIV  = 32'd8000000,
    parameter logic [9:0]  SCR_W     = 10'd640,
    parameter logic [9:0]  SCR_H     = 10'd480
) (
    input  logic  Clk,
    input  logic  reset,
    input  logic  is_new_game_start,
    input  logic  fire,
    input  logic  dynamite_fire,
    hook_if.master bus
);
    localparam logic signed [10:0] X_MAX = signed'({1'b0, SCR_W - 10'd1});
    localparam logic signed [10:0] Y_MAX = signed'({1'b0, SCR_H - 10'd1});

    hook_state_t state_q, state_d;
    logic [3:0]  r_q, r_d;
    logic [6:0]  n_q, n_d;
    logic        dir_up_q, dir_up_d;
    logic        fire_q;
    logic [9:0]  tailx_q, taily_q;

    logic               rst;
    logic               fire_rise;
    logic               tick;
    logic [31:0]        div;
    logic signed [10:0] nxt_x, nxt_y;
    logic signed [10:0] tx_d, ty_d;
    logic               edge_hit;

    assign rst       = reset | is_new_game_start;
    assign fire_rise = fire & ~fire_q;

`ifdef HOOK_DYNAMITE_EN
    logic dyn_q;
    logic explode_q, explode_d;
    logic dyn_rise;
    assign dyn_rise = dynamite_fire & ~dyn_q;
`else
    logic unused_dynamite;
    assign unused_dynamite = dynamite_fire;
`endif

    always_comb begin
        case (state_q)
            SWING:   div = SWING_DIV;
            LOADED:  div = LOAD_DIV;
            default: div = EXT_DIV;
        endcase
    end

    hook_tick_gen u_tick (
        .Clk   (Clk),
        .reset (rst),
        .clear (state_d != state_q),
        .div   (div),
        .tick  (tick)
    );

    // The edge test looks one step ahead so the tail never leaves the screen.
    always_comb begin
        nxt_x    = tail_pos(ORIGIN_X, n_q + 7'd1, DX[r_q]);
        nxt_y    = tail_pos(ORIGIN_Y, n_q + 7'd1, DY[r_q]);
        edge_hit = (n_q == 7'd127) ||
                   (nxt_x < 11'sd0) || (nxt_x > X_MAX) ||
                   (nxt_y < 11'sd0) || (nxt_y > Y_MAX);
    end

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        n_d      = n_q;
        dir_up_d = dir_up_q;
`ifdef HOOK_DYNAMITE_EN
        explode_d = 1'b0;
`endif
        case (state_q)
            SWING: begin
                if (fire_rise) begin
                    state_d = EXTEND;
                end else if (tick) begin
                    if (dir_up_q) begin
                        r_d = r_q + 4'd1;
                        if (r_q == 4'd9) dir_up_d = 1'b0;
                    end else begin
                        r_d = r_q - 4'd1;
                        if (r_q == 4'd1) dir_up_d = 1'b1;
                    end
                end
            end
            EXTEND: begin
                if (bus.is_catch_any)  state_d = LOADED;
                else if (edge_hit)     state_d = RETRACT;
                else if (tick)         n_d = n_q + 7'd1;
            end
            RETRACT: begin
                if (n_q == 7'd0) begin
                    state_d = SWING;
                end else if (tick) begin
                    n_d = n_q - 7'd1;
                    if (n_q == 7'd1) state_d = SWING;
                end
            end
            LOADED: begin
`ifdef HOOK_DYNAMITE_EN
                if (dyn_rise) begin
                    state_d   = RETRACT;
                    explode_d = 1'b1;
                end else
`endif
                if (n_q == 7'd0) begin
                    state_d = SWING;
                end else if (tick) begin
                    n_d = n_q - 7'd1;
                    if (n_q == 7'd1) state_d = SWING;
                end
            end
            default: state_d = SWING;
        endcase
    end

    // Tail tracks the next step count so it moves in the cycle right after a tick.
    always_comb begin
        tx_d = tail_pos(ORIGIN_X, n_d, DX[r_d]);
        ty_d = tail_pos(ORIGIN_Y, n_d, DY[r_d]);
    end

    always_ff @(posedge Clk) begin
        if (rst) begin
            state_q  <= SWING;
            r_q      <= 4'd5;
            n_q      <= 7'd0;
            dir_up_q <= 1'b1;
            fire_q   <= 1'b0;
            tailx_q  <= ORIGIN_X;
            taily_q  <= ORIGIN_Y;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            n_q      <= n_d;
            dir_up_q <= dir_up_d;
            fire_q   <= fire;
            tailx_q  <= tx_d[9:0];
            taily_q  <= ty_d[9:0];
        end
    end

`ifdef HOOK_DYNAMITE_EN
    always_ff @(posedge Clk) begin
        if (rst) begin
            dyn_q     <= 1'b0;
            explode_q <= 1'b0;
        end else begin
            dyn_q     <= dynamite_fire;
            explode_q <= explode_d;
        end
    end
    assign bus.is_explode = explode_q;
`else
    assign bus.is_explode = 1'b0;
`endif

    assign bus.tailx     = tailx_q;
    assign bus.taily     = taily_q;
    assign bus.R_mode    = r_q;
    assign bus.state_out = {1'b0, state_q};
endmodule

// File: tb/tb_hook_controller.sv
// Directed bench for hook_controller with SWING_DIV=4, EXT_DIV=2, LOAD_DIV=8.
module tb_hook_controller;
    logic Clk;
    logic reset;
    logic is_new_game_start;
    logic fire;
    logic dynamite_fire;
    int   checks;
    int   errors;

    hook_if bus ();

    hook_controller #(
        .SWING_DIV (32'd4),
        .EXT_DIV   (32'd2),
        .LOAD_DIV  (32'd8)
    ) dut (
        .Clk               (Clk),
        .reset             (reset),
        .is_new_game_start (is_new_game_start),
        .fire              (fire),
        .dynamite_fire     (dynamite_fire),
        .bus               (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset;
        fire = 1'b0;
        is_new_game_start = 1'b0;
        dynamite_fire = 1'b0;
        bus.is_catch_any = 1'b0;
        reset = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        fire = 1'b0;
        is_new_game_start = 1'b0;
        dynamite_fire = 1'b0;
        bus.is_catch_any = 1'b0;
        reset = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        checks++;
        if (bus.state_out !== 3'd0 || bus.R_mode !== 4'd5) begin
            errors++;
            $display("FAIL reset_state state=%0d rmode=%0d exp state=0 rmode=5", bus.state_out, bus.R_mode);
        end
        checks++;
        if (bus.tailx !== 10'd320 || bus.taily !== 10'd60 || bus.is_explode !== 1'b0) begin
            errors++;
            $display("FAIL reset_tail got (%0d,%0d) explode=%0d exp (320,60) explode=0", bus.tailx, bus.taily, bus.is_explode);
        end
        reset = 1'b0;
    endtask

    task automatic test_swing;
        int seq [17] = '{5, 6, 7, 8, 9, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1};
        do_reset();
        for (int k = 1; k <= 84; k++) begin
            @(negedge Clk);
            checks++;
            if (bus.R_mode !== 4'(seq[k / 5]) || bus.state_out !== 3'd0) begin
                errors++;
                $display("FAIL swing k=%0d rmode=%0d state=%0d exp rmode=%0d state=0", k, bus.R_mode, bus.state_out, seq[k / 5]);
            end
        end
    endtask

    task automatic test_fire_down;
        do_reset();
        fire = 1'b1;
        @(negedge Clk);
        checks++;
        if (bus.state_out !== 3'd1 || bus.taily !== 10'd60) begin
            errors++;
            $display("FAIL down_launch state=%0d y=%0d exp state=1 y=60", bus.state_out, bus.taily);
        end
        for (int s = 1; s <= 69; s++) begin
            repeat (3) @(negedge Clk);
            checks++;
            if (bus.taily !== 10'(60 + 6 * s) || bus.tailx !== 10'd320 || bus.state_out !== 3'd1) begin
                errors++;
                $display("FAIL down_extend s=%0d got (%0d,%0d) st=%0d exp (320,%0d) st=1", s, bus.tailx, bus.taily, bus.state_out, 60 + 6 * s);
            end
        end
        @(negedge Clk);
        checks++;
        if (bus.state_out !== 3'd2 || bus.taily !== 10'd474) begin
            errors++;
            $display("FAIL down_edge state=%0d y=%0d exp state=2 y=474", bus.state_out, bus.taily);
        end
        for (int s = 68; s >= 0; s--) begin
            repeat (3) @(negedge Clk);
            checks++;
            if (bus.taily !== 10'(60 + 6 * s) || bus.state_out !== ((s == 0) ? 3'd0 : 3'd2)) begin
                errors++;
                $display("FAIL down_retract s=%0d y=%0d st=%0d exp y=%0d st=%0d", s, bus.taily, bus.state_out, 60 + 6 * s, (s == 0) ? 0 : 2);
            end
        end
        checks++;
        if (bus.R_mode !== 4'd5 || bus.tailx !== 10'd320) begin
            errors++;
            $display("FAIL down_home rmode=%0d x=%0d exp rmode=5 x=320", bus.R_mode, bus.tailx);
        end
        fire = 1'b0;
    endtask

    task automatic test_fire_right;
        do_reset();
        repeat (25) @(negedge Clk);
        checks++;
        if (bus.R_mode !== 4'd10) begin
            errors++;
            $display("FAIL right_aim rmode=%0d exp 10", bus.R_mode);
        end
        fire = 1'b1;
        @(negedge Clk);
        for (int s = 1; s <= 53; s++) begin
            repeat (3) @(negedge Clk);
            checks++;
            if (bus.tailx !== 10'(320 + 6 * s) || bus.taily !== 10'd60 || bus.state_out !== 3'd1) begin
                errors++;
                $display("FAIL right_extend s=%0d got (%0d,%0d) st=%0d exp (%0d,60) st=1", s, bus.tailx, bus.taily, bus.state_out, 320 + 6 * s);
            end
        end
        @(negedge Clk);
        checks++;
        if (bus.state_out !== 3'd2 || bus.tailx !== 10'd638) begin
            errors++;
            $display("FAIL right_edge state=%0d x=%0d exp state=2 x=638", bus.state_out, bus.tailx);
        end
        for (int s = 52; s >= 0; s--) begin
            repeat (3) @(negedge Clk);
            checks++;
            if (bus.tailx !== 10'(320 + 6 * s) || bus.state_out !== ((s == 0) ? 3'd0 : 3'd2)) begin
                errors++;
                $display("FAIL right_retract s=%0d x=%0d st=%0d exp x=%0d st=%0d", s, bus.tailx, bus.state_out, 320 + 6 * s, (s == 0) ? 0 : 2);
            end
        end
        checks++;
        if (bus.R_mode !== 4'd10 || bus.taily !== 10'd60) begin
            errors++;
            $display("FAIL right_home rmode=%0d y=%0d exp rmode=10 y=60", bus.R_mode, bus.taily);
        end
        fire = 1'b0;
        repeat (5) @(negedge Clk);
        checks++;
        if (bus.R_mode !== 4'd9) begin
            errors++;
            $display("FAIL right_dir_kept rmode=%0d exp 9", bus.R_mode);
        end
    endtask

    task automatic test_catch;
        do_reset();
        repeat (10) @(negedge Clk);
        fire = 1'b1;
        repeat (31) @(negedge Clk);
        checks++;
        if (bus.tailx !== 10'd360 || bus.taily !== 10'd90 || bus.state_out !== 3'd1) begin
            errors++;
            $display("FAIL catch_reach got (%0d,%0d) st=%0d exp (360,90) st=1", bus.tailx, bus.taily, bus.state_out);
        end
        bus.is_catch_any = 1'b1;
        @(negedge Clk);
        bus.is_catch_any = 1'b0;
        checks++;
        if (bus.state_out !== 3'd3 || bus.tailx !== 10'd360 || bus.taily !== 10'd90) begin
            errors++;
            $display("FAIL catch_loaded st=%0d got (%0d,%0d) exp st=3 (360,90)", bus.state_out, bus.tailx, bus.taily);
        end
        for (int j = 1; j <= 10; j++) begin
            repeat (8) @(negedge Clk);
            if (j == 1) begin
                checks++;
                if (bus.taily !== 10'd90) begin
                    errors++;
                    $display("FAIL catch_hold y=%0d exp 90", bus.taily);
                end
            end
            @(negedge Clk);
            checks++;
            if (bus.tailx !== 10'(360 - 4 * j) || bus.taily !== 10'(90 - 3 * j) ||
                bus.state_out !== ((j == 10) ? 3'd0 : 3'd3)) begin
                errors++;
                $display("FAIL catch_return j=%0d got (%0d,%0d) st=%0d exp (%0d,%0d) st=%0d", j, bus.tailx, bus.taily,
                         bus.state_out, 360 - 4 * j, 90 - 3 * j, (j == 10) ? 0 : 3);
            end
        end
        checks++;
        if (bus.R_mode !== 4'd7) begin
            errors++;
            $display("FAIL catch_rmode rmode=%0d exp 7", bus.R_mode);
        end
        fire = 1'b0;
    endtask

    task automatic test_catch_edge_reset;
        bit found;
        do_reset();
        fire = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge Clk);
            if (bus.taily === 10'd474) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL edge_wait y=%0d exp 474 within 400 cycles", bus.taily);
        end
        bus.is_catch_any = 1'b1;
        @(negedge Clk);
        bus.is_catch_any = 1'b0;
        checks++;
        if (bus.state_out !== 3'd3) begin
            errors++;
            $display("FAIL catch_beats_edge state=%0d exp 3", bus.state_out);
        end
        fire = 1'b0;
        reset = 1'b1;
        @(negedge Clk);
        reset = 1'b0;
        checks++;
        if (bus.state_out !== 3'd0 || bus.tailx !== 10'd320 || bus.taily !== 10'd60 || bus.R_mode !== 4'd5) begin
            errors++;
            $display("FAIL reset_loaded st=%0d (%0d,%0d) rmode=%0d exp st=0 (320,60) rmode=5", bus.state_out, bus.tailx,
                     bus.taily, bus.R_mode);
        end
    endtask

    task automatic test_new_game;
        do_reset();
        fire = 1'b1;
        repeat (10) @(negedge Clk);
        checks++;
        if (bus.taily !== 10'd78 || bus.state_out !== 3'd1) begin
            errors++;
            $display("FAIL newgame_pre y=%0d st=%0d exp y=78 st=1", bus.taily, bus.state_out);
        end
        fire = 1'b0;
        is_new_game_start = 1'b1;
        @(negedge Clk);
        is_new_game_start = 1'b0;
        checks++;
        if (bus.state_out !== 3'd0 || bus.taily !== 10'd60 || bus.tailx !== 10'd320 || bus.R_mode !== 4'd5) begin
            errors++;
            $display("FAIL newgame st=%0d (%0d,%0d) rmode=%0d exp st=0 (320,60) rmode=5", bus.state_out, bus.tailx,
                     bus.taily, bus.R_mode);
        end
    endtask

    task automatic test_dynamite;
        do_reset();
        fire = 1'b1;
        repeat (31) @(negedge Clk);
        bus.is_catch_any = 1'b1;
        @(negedge Clk);
        bus.is_catch_any = 1'b0;
        checks++;
        if (bus.state_out !== 3'd3 || bus.taily !== 10'd120 || bus.is_explode !== 1'b0) begin
            errors++;
            $display("FAIL dyn_loaded st=%0d y=%0d explode=%0d exp st=3 y=120 explode=0", bus.state_out, bus.taily, bus.is_explode);
        end
        dynamite_fire = 1'b1;
        @(negedge Clk);
        dynamite_fire = 1'b0;
`ifdef HOOK_DYNAMITE_EN
        checks++;
        if (bus.is_explode !== 1'b1 || bus.state_out !== 3'd2 || bus.taily !== 10'd120) begin
            errors++;
            $display("FAIL dyn_pulse explode=%0d st=%0d y=%0d exp explode=1 st=2 y=120", bus.is_explode, bus.state_out, bus.taily);
        end
        @(negedge Clk);
        checks++;
        if (bus.is_explode !== 1'b0 || bus.state_out !== 3'd2) begin
            errors++;
            $display("FAIL dyn_one_cycle explode=%0d st=%0d exp explode=0 st=2", bus.is_explode, bus.state_out);
        end
        repeat (2) @(negedge Clk);
        checks++;
        if (bus.taily !== 10'd114) begin
            errors++;
            $display("FAIL dyn_fast_rate y=%0d exp 114", bus.taily);
        end
`else
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.is_explode !== 1'b0 || bus.state_out !== 3'd3 || bus.taily !== 10'd120) begin
                errors++;
                $display("FAIL dyn_ignored i=%0d explode=%0d st=%0d y=%0d exp explode=0 st=3 y=120", i, bus.is_explode,
                         bus.state_out, bus.taily);
            end
            @(negedge Clk);
        end
`endif
        fire = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        fire = 1'b0;
        is_new_game_start = 1'b0;
        dynamite_fire = 1'b0;
        bus.is_catch_any = 1'b0;
        test_reset();
        test_swing();
        test_fire_down();
        test_fire_right();
        test_catch();
        test_catch_edge_reset();
        test_new_game();
        test_dynamite();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
